// File: rtl/rat_ckpt_pkg.sv
// Shared widths, types and helpers for the checkpointed rename map table.
// Every other rat_ckpt file imports this package.
package rat_ckpt_pkg;
    localparam int N        = 2;
    localparam int ARCH_SZ  = 32;
    localparam int PHYS_SZ  = 64;
    localparam int CKPTS    = 4;
    localparam int FL_SZ    = PHYS_SZ - ARCH_SZ;
    localparam int ARN_W    = $clog2(ARCH_SZ);
    localparam int PRN_W    = $clog2(PHYS_SZ);
    localparam int CKPT_W   = $clog2(CKPTS);
    localparam int SLOT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int FL_PTR_W = $clog2(FL_SZ) + 1;
    localparam int CK_PTR_W = CKPT_W + 1;

    typedef logic [ARN_W-1:0]    arn_t;
    typedef logic [PRN_W-1:0]    prn_t;
    typedef logic [CKPT_W-1:0]   ckpt_id_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [CK_PTR_W-1:0] ck_ptr_t;
    typedef logic [SLOT_W:0]     slot_cnt_t;
    typedef logic [ARCH_SZ-1:0][PRN_W-1:0] map_t;

    typedef struct packed {
        map_t    map;
        fl_ptr_t head;
    } snap_t;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < ARCH_SZ; i++) begin
            m[i] = prn_t'(i);
        end
        return m;
    endfunction
endpackage

// File: rtl/rat_ckpt_free_list.sv
// Circular free-PRN FIFO with extended (wrap-bit) pointers, N pops and N pushes per cycle,
// head restore for branch recovery and full reclaim on flush.
module rat_ckpt_free_list
    import rat_ckpt_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  fl_ptr_t                 pop_cnt_i,
    input  logic [N-1:0]            push_valid_i,
    input  logic [N-1:0][PRN_W-1:0] push_prn_i,
    input  logic                    restore_i,
    input  fl_ptr_t                 restore_head_i,
    input  logic                    flush_i,
    output logic [N-1:0][PRN_W-1:0] head_prn_o,
    output fl_ptr_t                 head_o,
    output fl_ptr_t                 free_cnt_o
);
    localparam int IDX_W = FL_PTR_W - 1;

    prn_t    fl_q [FL_SZ];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    fl_ptr_t push_ptr [N];
    fl_ptr_t rd_ptr;
    fl_ptr_t fill_after;

    always_comb begin
        tail_d = tail_q;
        for (int i = 0; i < N; i++) begin
            push_ptr[i] = tail_d;
            if (push_valid_i[i]) tail_d = tail_d + fl_ptr_t'(1);
        end
        // Non-free slots are exactly the in-flight PRNs, so placing head one full lap
        // behind the new tail hands all of them back at once.
        if (flush_i)        head_d = {~tail_d[FL_PTR_W-1], tail_d[IDX_W-1:0]};
        else if (restore_i) head_d = restore_head_i;
        else                head_d = head_q + pop_cnt_i;
    end

    always_comb begin
        rd_ptr = head_q;
        for (int k = 0; k < N; k++) begin
            rd_ptr        = head_q + fl_ptr_t'(k);
            head_prn_o[k] = fl_q[rd_ptr[IDX_W-1:0]];
        end
    end

    assign head_o     = head_q;
    assign free_cnt_o = tail_q - head_q;
    assign fill_after = tail_d - head_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= fl_ptr_t'(FL_SZ);
            for (int i = 0; i < FL_SZ; i++) begin
                fl_q[i] <= prn_t'(ARCH_SZ + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < N; i++) begin
                if (push_valid_i[i]) fl_q[push_ptr[i][IDX_W-1:0]] <= push_prn_i[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) assert (fill_after <= fl_ptr_t'(FL_SZ));
    end
endmodule

// File: rtl/rat_ckpt.sv
// Rename map table with per-branch checkpoints: single-cycle mispredict recovery from
// snapshots, full flush reload from the retirement map.
module rat_ckpt
    import rat_ckpt_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    // Group handshake: rn_valid_i qualifies each slot; rn_ready_o accepts the whole group
    // in the same cycle or none of it, and an unaccepted group must be held and re-presented.
    input  logic [N-1:0]             rn_valid_i,
    input  logic [N-1:0][ARN_W-1:0]  rn_dest_arn_i,
    input  logic [N-1:0][ARN_W-1:0]  rn_op1_arn_i,
    input  logic [N-1:0][ARN_W-1:0]  rn_op2_arn_i,
    input  logic [N-1:0]             rn_is_branch_i,
    output logic                     rn_ready_o,
    output logic [N-1:0][PRN_W-1:0]  rn_op1_prn_o,
    output logic [N-1:0][PRN_W-1:0]  rn_op2_prn_o,
    output logic [N-1:0][PRN_W-1:0]  rn_dest_prn_o,
    output logic [N-1:0][PRN_W-1:0]  rn_old_prn_o,
    output logic [N-1:0][CKPT_W-1:0] rn_ckpt_id_o,
    input  logic [N-1:0]             ct_free_valid_i,
    input  logic [N-1:0][PRN_W-1:0]  ct_free_prn_i,
    input  logic                     br_valid_i,
    input  logic [CKPT_W-1:0]        br_ckpt_id_i,
    input  logic                     br_mispredict_i,
    input  logic                     flush_i,
    input  map_t                     flush_map_i,
    output logic [FL_PTR_W-1:0]      dbg_free_cnt_o,
    output logic [CK_PTR_W-1:0]      dbg_ck_live_o
);
    map_t      table_q;
    snap_t     snap_q [CKPTS];
    ck_ptr_t   ck_head_q, ck_tail_q;
    logic [CKPTS-1:0] resolved_q;

    fl_ptr_t   fl_head, fl_free_cnt;
    logic [N-1:0][PRN_W-1:0] fl_head_prn;

    map_t      work;
    slot_cnt_t pops, brs;
    logic [N-1:0][PRN_W-1:0]  op1_raw, op2_raw, dest_raw, old_raw;
    logic [N-1:0][CKPT_W-1:0] ckid_raw;
    logic [N-1:0] snap_we;
    ckpt_id_t  snap_id [N];
    snap_t     snap_w  [N];

    ck_ptr_t   ck_live, ck_free, retire_cnt;
    ckpt_id_t  br_off, kid;
    logic      br_live, recover, rec_hit, res_hit, accept, stop;
    logic [CKPTS-1:0] res_vec;

    assign ck_live = ck_tail_q - ck_head_q;
    assign ck_free = ck_ptr_t'(CKPTS) - ck_live;
    assign recover = br_valid_i && br_mispredict_i;
    assign br_off  = br_ckpt_id_i - ck_head_q[CKPT_W-1:0];
    assign br_live = ck_ptr_t'(br_off) < ck_live;
    assign rec_hit = !flush_i && recover && br_live;
    assign res_hit = !flush_i && br_valid_i && !br_mispredict_i && br_live;

    // Walk the group in slot order so younger slots see older slots' new mappings.
    always_comb begin
        work     = table_q;
        pops     = '0;
        brs      = '0;
        op1_raw  = '0;
        op2_raw  = '0;
        dest_raw = '0;
        old_raw  = '0;
        ckid_raw = '0;
        snap_we  = '0;
        for (int i = 0; i < N; i++) begin
            snap_id[i] = '0;
            snap_w[i]  = '0;
            if (rn_valid_i[i]) begin
                if (rn_op1_arn_i[i] != '0) op1_raw[i] = work[rn_op1_arn_i[i]];
                if (rn_op2_arn_i[i] != '0) op2_raw[i] = work[rn_op2_arn_i[i]];
                if (rn_dest_arn_i[i] != '0) begin
                    old_raw[i]              = work[rn_dest_arn_i[i]];
                    dest_raw[i]             = fl_head_prn[pops[SLOT_W-1:0]];
                    work[rn_dest_arn_i[i]]  = dest_raw[i];
                    pops                    = pops + slot_cnt_t'(1);
                end
                if (rn_is_branch_i[i]) begin
                    snap_we[i]     = 1'b1;
                    snap_id[i]     = ck_tail_q[CKPT_W-1:0] + ckpt_id_t'(brs);
                    ckid_raw[i]    = snap_id[i];
                    snap_w[i].map  = work;
                    snap_w[i].head = fl_head + fl_ptr_t'(pops);
                    brs            = brs + slot_cnt_t'(1);
                end
            end
        end
    end

    assign accept = !flush_i && !recover
                 && (fl_ptr_t'(pops) <= fl_free_cnt)
                 && (ck_ptr_t'(brs) <= ck_free);

    assign rn_ready_o    = accept;
    assign rn_op1_prn_o  = accept ? op1_raw  : '0;
    assign rn_op2_prn_o  = accept ? op2_raw  : '0;
    assign rn_dest_prn_o = accept ? dest_raw : '0;
    assign rn_old_prn_o  = accept ? old_raw  : '0;
    assign rn_ckpt_id_o  = accept ? ckid_raw : '0;

    // A resolution arriving this cycle counts, so the oldest run of resolved slots frees now.
    always_comb begin
        res_vec = resolved_q;
        if (res_hit) res_vec[br_ckpt_id_i] = 1'b1;
        retire_cnt = '0;
        stop       = 1'b0;
        kid        = '0;
        for (int k = 0; k < CKPTS; k++) begin
            kid = ck_head_q[CKPT_W-1:0] + ckpt_id_t'(k);
            if (!stop && (ck_ptr_t'(k) < ck_live) && res_vec[kid]) begin
                retire_cnt   = retire_cnt + ck_ptr_t'(1);
                res_vec[kid] = 1'b0;
            end else begin
                stop = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (accept && snap_we[i]) res_vec[snap_id[i]] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            table_q    <= identity_map();
            ck_head_q  <= '0;
            ck_tail_q  <= '0;
            resolved_q <= '0;
        end else if (flush_i) begin
            table_q    <= flush_map_i;
            ck_tail_q  <= ck_head_q;
            resolved_q <= '0;
        end else if (rec_hit) begin
            table_q    <= snap_q[br_ckpt_id_i].map;
            ck_tail_q  <= ck_head_q + ck_ptr_t'(br_off);
        end else if (!recover) begin
            if (accept) table_q <= work;
            ck_tail_q  <= ck_tail_q + (accept ? ck_ptr_t'(brs) : '0);
            ck_head_q  <= ck_head_q + retire_cnt;
            resolved_q <= res_vec;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (accept && snap_we[i]) snap_q[snap_id[i]] <= snap_w[i];
        end
    end

    rat_ckpt_free_list u_free_list (
        .clock          (clock),
        .reset          (reset),
        .pop_cnt_i      (accept ? fl_ptr_t'(pops) : '0),
        .push_valid_i   (ct_free_valid_i),
        .push_prn_i     (ct_free_prn_i),
        .restore_i      (rec_hit),
        .restore_head_i (snap_q[br_ckpt_id_i].head),
        .flush_i        (flush_i),
        .head_prn_o     (fl_head_prn),
        .head_o         (fl_head),
        .free_cnt_o     (fl_free_cnt)
    );

    assign dbg_free_cnt_o = fl_free_cnt;
    assign dbg_ck_live_o  = ck_live;
endmodule
